rab_cfg_master: RTL and testbench

RAB_CFG_MASTER -- requirements
Module: rab_cfg_master

---
 rtl/rab_cfg_master_if.sv | 25 ++
 rtl/rab_cfg_master.sv | 164 ++++++++++++++++
 tb/tb_rab_cfg_master.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rab_cfg_master_if.sv
// AXI-Lite write-channel bundle between rab_cfg_master and a configuration slave.
interface rab_cfg_master_if #(
    parameter int unsigned DW = 32
) ();
    logic [31:0]     m_axi_awaddr;
    logic            m_axi_awvalid;
    logic            m_axi_awready;
    logic [DW-1:0]   m_axi_wdata;
    logic [DW/8-1:0] m_axi_wstrb;
    logic            m_axi_wvalid;
    logic            m_axi_wready;
    logic [1:0]      m_axi_bresp;
    logic            m_axi_bvalid;
    logic            m_axi_bready;

    modport master (
        output m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid, m_axi_bready,
        input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid
    );

    modport slave (
        input  m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid, m_axi_bready,
        output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid
    );
endinterface

// File: rtl/rab_cfg_master.sv
// Queued configuration-write master: buffers commands in a small FIFO and
// issues each one as a single AXI-Lite write, counting responses and latching errors.
module rab_cfg_master #(
    parameter int unsigned CMD_DEPTH           = 4,
    parameter int unsigned C_AXICFG_DATA_WIDTH = 32
) (
    input  logic                             s_axi_aclk,
    input  logic                             s_axi_areset,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [31:0]                      cmd_addr,
    input  logic [C_AXICFG_DATA_WIDTH-1:0]   cmd_data,
    input  logic [C_AXICFG_DATA_WIDTH/8-1:0] cmd_strb,
    rab_cfg_master_if.master                 axi,
    output logic                             busy,
    output logic                             err_flag,
    input  logic                             err_clr,
    output logic [15:0]                      wr_count
);
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = C_AXICFG_DATA_WIDTH;
    localparam int unsigned SW  = DW / 8;
    localparam int unsigned PW  = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned WCW = 16;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    cmd_t           mem_q [CMD_DEPTH];
    cmd_t           cmd_in_c;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    state_t         state_q, state_d;
    cmd_t           out_q, out_d;
    logic           awvalid_q, awvalid_d;
    logic           wvalid_q, wvalid_d;
    logic           bready_q, bready_d;
    logic           err_q, err_d;
    logic           busy_q, busy_d;
    logic           ready_q, ready_d;
    logic [WCW-1:0] wr_count_q, wr_count_d;
    logic           push_c, pop_c;

    assign cmd_in_c = '{addr: cmd_addr, data: cmd_data, strb: cmd_strb};

    // Command storage; contents are don't-care until written, so no reset.
    always_ff @(posedge s_axi_aclk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= cmd_in_c;
        end
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            out_q      <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            out_q      <= out_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Transaction sequencing plus FIFO bookkeeping; a response error wins over err_clr.
    always_comb begin
        state_d    = state_q;
        out_d      = out_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        err_d      = err_q;
        wr_count_d = wr_count_q;
        push_c     = cmd_valid && ready_q;
        pop_c      = 1'b0;

        if (err_clr) begin
            err_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop_c     = 1'b1;
                    out_d     = mem_q[rd_ptr_q];
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (awvalid_q && axi.m_axi_awready) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && axi.m_axi_wready) begin
                    wvalid_d = 1'b0;
                end
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (axi.m_axi_bvalid && bready_q) begin
                    bready_d   = 1'b0;
                    wr_count_d = wr_count_q + WCW'(1);
                    if (axi.m_axi_bresp != 2'b00) begin
                        err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        wr_ptr_d = push_c ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop_c  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push_c) - CW'(pop_c);
        ready_d  = (count_d != CW'(CMD_DEPTH));
        busy_d   = (count_d != '0) || (state_d != IDLE);
    end

    assign cmd_ready         = ready_q;
    assign busy              = busy_q;
    assign err_flag          = err_q;
    assign wr_count          = wr_count_q;
    assign axi.m_axi_awaddr  = out_q.addr;
    assign axi.m_axi_wdata   = out_q.data;
    assign axi.m_axi_wstrb   = out_q.strb;
    assign axi.m_axi_awvalid = awvalid_q;
    assign axi.m_axi_wvalid  = wvalid_q;
    assign axi.m_axi_bready  = bready_q;
endmodule

// File: tb/tb_rab_cfg_master.sv
// Self-checking bench for rab_cfg_master: vector table, directed corner cases,
// and randomized traffic checked against a transaction-level reference model.
module tb_rab_cfg_master;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_data;
    logic [3:0]  cmd_strb;
    logic        busy;
    logic        err_flag;
    logic        err_clr;
    logic [15:0] wr_count;

    always #5 clk = ~clk;

    rab_cfg_master_if #(.DW(32)) axi ();

    rab_cfg_master #(.CMD_DEPTH(DEPTH), .C_AXICFG_DATA_WIDTH(32)) dut (
        .s_axi_aclk  (clk),
        .s_axi_areset(rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .cmd_strb    (cmd_strb),
        .axi         (axi),
        .busy        (busy),
        .err_flag    (err_flag),
        .err_clr     (err_clr),
        .wr_count    (wr_count)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_aw  = 0;
    int n_w   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of accepted commands plus one in-flight write.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } mcmd_t;

    mcmd_t       mq[$];
    mcmd_t       m_cur;
    bit          m_fl, m_awd, m_wd, m_err;
    logic [15:0] m_cnt;

    function automatic void model_reset();
        mq.delete();
        m_cur = '{32'h0, 32'h0, 4'h0};
        m_fl  = 1'b0;
        m_awd = 1'b0;
        m_wd  = 1'b0;
        m_err = 1'b0;
        m_cnt = 16'h0;
    endfunction

    task automatic check_model();
        chk("awvalid",   axi.m_axi_awvalid, 32'(m_fl && !m_awd));
        chk("wvalid",    axi.m_axi_wvalid,  32'(m_fl && !m_wd));
        chk("bready",    axi.m_axi_bready,  32'(m_fl && m_awd && m_wd));
        chk("cmd_ready", cmd_ready,         32'(mq.size() < DEPTH));
        chk("busy",      busy,              32'(mq.size() > 0 || m_fl));
        chk("err_flag",  err_flag,          32'(m_err));
        chk("wr_count",  wr_count,          32'(m_cnt));
        chk("awaddr",    axi.m_axi_awaddr,  m_cur.addr);
        chk("wdata",     axi.m_axi_wdata,   m_cur.data);
        chk("wstrb",     axi.m_axi_wstrb,   32'(m_cur.strb));
    endtask

    // One clock: decide what transfers at the coming edge, clock, update model, compare.
    task automatic step();
        bit hs_aw, hs_w, hs_b, push, pop;
        hs_aw = m_fl && !m_awd && axi.m_axi_awready;
        hs_w  = m_fl && !m_wd && axi.m_axi_wready;
        hs_b  = m_fl && m_awd && m_wd && axi.m_axi_bvalid;
        push  = cmd_valid && (mq.size() < DEPTH);
        pop   = !m_fl && (mq.size() > 0);
        if (axi.m_axi_awvalid && axi.m_axi_awready) n_aw++;
        if (axi.m_axi_wvalid && axi.m_axi_wready) n_w++;
        @(posedge clk);
        #1;
        if (err_clr) m_err = 1'b0;
        if (hs_b) begin
            m_fl  = 1'b0;
            m_cnt = m_cnt + 16'd1;
            if (axi.m_axi_bresp != 2'b00) m_err = 1'b1;
        end
        if (hs_aw) m_awd = 1'b1;
        if (hs_w)  m_wd  = 1'b1;
        if (pop) begin
            m_cur = mq.pop_front();
            m_fl  = 1'b1;
            m_awd = 1'b0;
            m_wd  = 1'b0;
        end
        if (push) mq.push_back('{cmd_addr, cmd_data, cmd_strb});
        check_model();
    endtask

    task automatic idle_inputs();
        cmd_valid         = 1'b0;
        cmd_addr          = 32'h0;
        cmd_data          = 32'h0;
        cmd_strb          = 4'h0;
        err_clr           = 1'b0;
        axi.m_axi_awready = 1'b0;
        axi.m_axi_wready  = 1'b0;
        axi.m_axi_bvalid  = 1'b0;
        axi.m_axi_bresp   = 2'b00;
    endtask

    task automatic set_cmd(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_strb  = s;
    endtask

    task automatic drain();
        cmd_valid         = 1'b0;
        err_clr           = 1'b0;
        axi.m_axi_awready = 1'b1;
        axi.m_axi_wready  = 1'b1;
        axi.m_axi_bvalid  = 1'b1;
        axi.m_axi_bresp   = 2'b00;
        for (int k = 0; k < 60 && busy; k++) step();
        chk("drain_done", busy, 32'h0);
        idle_inputs();
    endtask

    typedef struct {
        bit          cv;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        bit          awr, wr, bv;
        logic [1:0]  br;
        bit          clr;
        bit          e_awv, e_wv, e_brdy, e_rdy, e_busy, e_err;
        logic [15:0] e_cnt;
        logic [31:0] e_awaddr;
    } vec_t;

    vec_t tbl[17];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int base_aw, base_w;
        logic [15:0] base_cnt;
        bit accepted;

        //          cv    addr      data          strb  awr   wr    bv    br     clr   awv   wv    brdy  rdy   busy  err   cnt     awaddr
        tbl[0]  = '{1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 32'h00};
        tbl[1]  = '{1'b0, 32'h0,  32'h0,         4'h0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 32'h10};
        tbl[2]  = '{1'b0, 32'h0,  32'h0,         4'h0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0, 32'h10};
        tbl[3]  = '{1'b0, 32'h0,  32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1, 32'h10};
        tbl[4]  = '{1'b0, 32'h0,  32'h0,         4'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1, 32'h10};
        tbl[5]  = '{1'b1, 32'h20, 32'h1111_1111, 4'hF, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1, 32'h10};
        tbl[6]  = '{1'b0, 32'h0,  32'h0,         4'h0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1, 32'h20};
        tbl[7]  = '{1'b0, 32'h0,  32'h0,         4'h0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd1, 32'h20};
        tbl[8]  = '{1'b0, 32'h0,  32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2, 32'h20};
        tbl[9]  = '{1'b0, 32'h0,  32'h0,         4'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2, 32'h20};
        tbl[10] = '{1'b0, 32'h0,  32'h0,         4'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2, 32'h20};
        tbl[11] = '{1'b1, 32'h30, 32'h2222_2222, 4'h3, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2, 32'h20};
        tbl[12] = '{1'b0, 32'h0,  32'h0,         4'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2, 32'h30};
        tbl[13] = '{1'b0, 32'h0,  32'h0,         4'h0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2, 32'h30};
        tbl[14] = '{1'b0, 32'h0,  32'h0,         4'h0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd2, 32'h30};
        tbl[15] = '{1'b0, 32'h0,  32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd3, 32'h30};
        tbl[16] = '{1'b0, 32'h0,  32'h0,         4'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd3, 32'h30};

        // Reset values appear without any clock edge.
        idle_inputs();
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_awvalid",   axi.m_axi_awvalid, 32'h0);
        chk("rst_wvalid",    axi.m_axi_wvalid,  32'h0);
        chk("rst_bready",    axi.m_axi_bready,  32'h0);
        chk("rst_busy",      busy,              32'h0);
        chk("rst_err",       err_flag,          32'h0);
        chk("rst_wr_count",  wr_count,          32'h0);
        chk("rst_cmd_ready", cmd_ready,         32'h1);
        chk("rst_awaddr",    axi.m_axi_awaddr,  32'h0);
        chk("rst_wdata",     axi.m_axi_wdata,   32'h0);
        chk("rst_wstrb",     axi.m_axi_wstrb,   32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();

        // Vector table: single write, error response, split handshakes, set-beats-clear.
        for (int i = 0; i < 17; i++) begin
            cmd_valid         = tbl[i].cv;
            cmd_addr          = tbl[i].a;
            cmd_data          = tbl[i].d;
            cmd_strb          = tbl[i].s;
            axi.m_axi_awready = tbl[i].awr;
            axi.m_axi_wready  = tbl[i].wr;
            axi.m_axi_bvalid  = tbl[i].bv;
            axi.m_axi_bresp   = tbl[i].br;
            err_clr           = tbl[i].clr;
            step();
            chk($sformatf("tbl%0d_awvalid", i), axi.m_axi_awvalid, 32'(tbl[i].e_awv));
            chk($sformatf("tbl%0d_wvalid", i),  axi.m_axi_wvalid,  32'(tbl[i].e_wv));
            chk($sformatf("tbl%0d_bready", i),  axi.m_axi_bready,  32'(tbl[i].e_brdy));
            chk($sformatf("tbl%0d_ready", i),   cmd_ready,         32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_busy", i),    busy,              32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_err", i),     err_flag,          32'(tbl[i].e_err));
            chk($sformatf("tbl%0d_cnt", i),     wr_count,          32'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_awaddr", i),  axi.m_axi_awaddr,  tbl[i].e_awaddr);
            if (i == 1) chk("tbl1_wdata", axi.m_axi_wdata, 32'hDEAD_BEEF);
        end
        chk("tbl_aw_beats", 32'(n_aw), 32'd3);
        chk("tbl_w_beats",  32'(n_w),  32'd3);
        idle_inputs();

        // Fill the FIFO with AW stalled; a further command must wait for a pop.
        base_cnt = wr_count;
        base_aw  = n_aw;
        for (int k = 0; k < 5; k++) begin
            set_cmd(32'h100 + 32'(k * 4), 32'hA000_0000 + 32'(k), 4'hF);
            step();
            chk($sformatf("fill%0d_ready", k), cmd_ready, (k < 4) ? 32'h1 : 32'h0);
        end
        set_cmd(32'h114, 32'hA000_0005, 4'hF);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("full_hold_ready", cmd_ready, 32'h0);
            chk("full_no_aw", 32'(n_aw - base_aw), 32'h0);
        end
        axi.m_axi_awready = 1'b1;
        axi.m_axi_wready  = 1'b1;
        axi.m_axi_bvalid  = 1'b1;
        accepted = 1'b0;
        for (int k = 0; k < 20 && !accepted; k++) begin
            accepted = cmd_ready;
            step();
        end
        chk("sixth_accepted", 32'(accepted), 32'h1);
        drain();
        chk("fill_wr_count", 32'(wr_count - base_cnt), 32'd6);
        chk("fill_aw_beats", 32'(n_aw - base_aw), 32'd6);

        // W handshake three cycles after AW; response phase only after both.
        set_cmd(32'h40, 32'h1234_5678, 4'hF);
        step();
        cmd_valid = 1'b0;
        step();
        chk("wlag_start_wvalid", axi.m_axi_wvalid, 32'h1);
        axi.m_axi_awready = 1'b1;
        step();
        axi.m_axi_awready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("wlag_wvalid", axi.m_axi_wvalid, 32'h1);
            chk("wlag_wdata",  axi.m_axi_wdata,  32'h1234_5678);
            chk("wlag_bready", axi.m_axi_bready, 32'h0);
            step();
        end
        chk("wlag_wdata_last", axi.m_axi_wdata, 32'h1234_5678);
        axi.m_axi_wready = 1'b1;
        step();
        chk("wlag_bready_set", axi.m_axi_bready, 32'h1);
        chk("wlag_wvalid_clr", axi.m_axi_wvalid, 32'h0);
        axi.m_axi_wready = 1'b0;
        drain();

        // Reset in the middle of a write with two commands queued.
        for (int k = 0; k < 3; k++) begin
            set_cmd(32'h200 + 32'(k * 4), 32'hB000_0000 + 32'(k), 4'hF);
            step();
        end
        cmd_valid = 1'b0;
        chk("pre_rst_awvalid", axi.m_axi_awvalid, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_awvalid",   axi.m_axi_awvalid, 32'h0);
        chk("mid_rst_wvalid",    axi.m_axi_wvalid,  32'h0);
        chk("mid_rst_busy",      busy,              32'h0);
        chk("mid_rst_cmd_ready", cmd_ready,         32'h1);
        chk("mid_rst_err",       err_flag,          32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        base_aw = n_aw;
        axi.m_axi_awready = 1'b1;
        axi.m_axi_wready  = 1'b1;
        for (int k = 0; k < 6; k++) step();
        chk("post_rst_no_aw", 32'(n_aw - base_aw), 32'h0);
        idle_inputs();

        // Counter wrap from 0xFFFF to 0 on one more write.
        force dut.wr_count_q = 16'hFFFF;
        m_cnt = 16'hFFFF;
        step();
        release dut.wr_count_q;
        chk("wrap_preload", wr_count, 32'hFFFF);
        set_cmd(32'h300, 32'hC0DE_0001, 4'h1);
        step();
        drain();
        chk("wrap_zero", wr_count, 32'h0);

        // Randomized traffic with slave readiness varying by phase.
        for (int i = 0; i < 3000; i++) begin
            int unsigned pct;
            pct = (((i / 200) % 3) == 0) ? 90 : ((((i / 200) % 3) == 1) ? 50 : 10);
            cmd_valid         = ($urandom_range(0, 1) == 1);
            cmd_addr          = $urandom;
            cmd_data          = $urandom;
            cmd_strb          = 4'($urandom);
            axi.m_axi_awready = ($urandom_range(0, 99) < pct);
            axi.m_axi_wready  = ($urandom_range(0, 99) < pct);
            axi.m_axi_bvalid  = ($urandom_range(0, 1) == 1);
            axi.m_axi_bresp   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            err_clr           = ($urandom_range(0, 9) == 0);
            step();
        end
        drain();
        chk("final_queue_empty", 32'(mq.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
